// File: rtl/bus_drive_pkg.sv
// Shared types and helpers for the bus drive sequencer: FSM states, direction constant,
// and phase counter width.
package bus_drive_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, DRIVE, TURN} state_t;

    localparam logic DIR_A_TO_B = 1'b1;

    // The counter must hold the largest load value; it never needs fewer than one bit.
    function automatic int cnt_width(input int hold, input int turn);
        int m;
        m = (hold > turn) ? hold : turn;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with a zero flag, used for both the DRIVE and TURN phases.
module phase_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - W'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_drive_sequencer.sv
// Sequences a transceiver output enable through SETUP/DRIVE/TURN around a registered A-side word.
// Optional sticky contention detection is enabled with BUS_DRIVE_CONTENTION_CHECK_EN.
module bus_drive_sequencer
    import bus_drive_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             bus_busy,
    output logic [WIDTH-1:0] a_data,
    output logic             oe_n,
    output logic             dir,
    output logic             done,
    output logic             contention_err
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, TURNAROUND);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = (TURNAROUND > 0) ? CNT_W'(TURNAROUND - 1) : '0;

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "bus_drive_sequencer: HOLD_CYCLES must be at least 1");
    end

    state_t             state, state_next;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = HOLD_LOAD;
        case (state)
            IDLE:  if (in_valid) state_next = SETUP;
            SETUP: if (!bus_busy) begin
                state_next = DRIVE;
                cnt_load   = 1'b1;
                cnt_val    = HOLD_LOAD;
            end
            DRIVE: if (cnt_zero) begin
                if (TURNAROUND == 0) begin
                    state_next = IDLE;
                end else begin
                    state_next = TURN;
                    cnt_load   = 1'b1;
                    cnt_val    = TURN_LOAD;
                end
            end else begin
                cnt_dec = 1'b1;
            end
            TURN:  if (cnt_zero) state_next = IDLE;
                   else          cnt_dec    = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    phase_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // The word is captured only on the accept edge and then held for the whole transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            a_data <= '0;
        else if (state == IDLE && in_valid)
            a_data <= in_data;
    end

    // Enables decode from registered state only, so they cannot glitch on input changes.
    assign in_ready = (state == IDLE);
    assign oe_n     = (state != DRIVE);
    assign done     = (state == DRIVE) && cnt_zero;
    assign dir      = DIR_A_TO_B;

`ifdef BUS_DRIVE_CONTENTION_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contention_err <= 1'b0;
        end else if (!oe_n && bus_busy) begin
            contention_err <= 1'b1;
            $error("bus_drive_sequencer: bus contention at time %0t", $time);
        end
    end
`else
    assign contention_err = 1'b0;
`endif

endmodule
